// File: rtl/add_serial_pkg.sv
// Shared types and constants for the bit-serial adder scheduler.
// Holds the FSM state encoding, default sizes and the wait-counter width helper.
package add_serial_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_ADD_LATENCY = 10;

  // The wait counter only ever holds values 0..lat-1.
  function automatic int cnt_width(input int lat);
    if (lat <= 2) return 1;
    return $clog2(lat);
  endfunction

endpackage

// File: rtl/add_serial_sched_rr_arbiter.sv
// Combinational round-robin pick: first asserted request searching ptr+1,
// ptr+2, ... modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [IDW-1:0]     win_id,
  output logic               any_req
);

  int p;
  int idx;

  // Walk from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    win_id  = '0;
    any_req = 1'b0;
    p       = int'(ptr);
    idx     = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (p + k) % NUM_REQ;
      if (req[idx]) begin
        win_id  = IDW'(idx);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/add_serial_sched.sv
// Round-robin scheduler sharing one bit-serial adder among NUM_REQ requesters.
// Latches the winner's operands, pulses add_en, waits ADD_LATENCY cycles, returns the sum.
module add_serial_sched
  import add_serial_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = DEF_WIDTH,
  parameter int ADD_LATENCY = DEF_ADD_LATENCY,
  parameter int IDW         = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       done,
  output logic [WIDTH-1:0]         result,
  output logic [IDW-1:0]           gnt_id,
  output logic                     busy,
  output logic                     add_en,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  input  logic [WIDTH-1:0]         add_out,
  output state_e                   dbg_state
);

  localparam int CW = cnt_width(ADD_LATENCY);

  // Handshake: req is a level sampled only in IDLE; the operation is committed
  // once granted and ends with a single-cycle done pulse to the granted index.

  state_e          state, state_n;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  win_id;
  logic            any_req;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] res_q;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .req     (req),
    .ptr     (ptr),
    .win_id  (win_id),
    .any_req (any_req)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (any_req) state_n = LAUNCH;
      LAUNCH:  state_n = WAIT;
      WAIT:    if (cnt == '0) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= IDW'(NUM_REQ - 1);
      gnt_id <= '0;
      add_a  <= '0;
      add_b  <= '0;
      cnt    <= '0;
      res_q  <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_id <= win_id;
            add_a  <= req_a[win_id*WIDTH +: WIDTH];
            add_b  <= req_b[win_id*WIDTH +: WIDTH];
          end
        end
        LAUNCH: cnt <= CW'(ADD_LATENCY - 1);
        WAIT: begin
          if (cnt == '0) res_q <= add_out;
          else           cnt   <= cnt - CW'(1);
        end
        RESP: ptr <= gnt_id;
        default: ;
      endcase
    end
  end

  always_comb begin
    done   = '0;
    result = '0;
    if (state == RESP) begin
      done[gnt_id] = 1'b1;
      result       = res_q;
    end
  end

  assign add_en    = (state == LAUNCH);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule
